hex_scroll_monitor: RTL and testbench

- Receive-side counterpart of the six-digit 7-segment scroller.
- Samples the six active-low segment buses HEX0..HEX5 and decodes each glyph back to a digit code.
- Filters glitches, then classifies each change of the displayed frame as a one-position rotation up, a rotation down, or an error.
- Counts steps and errors; used as an on-board self-check and as a scoreboard front-end in simulation.

---
 rtl/hex_scroll_monitor.sv | 240 ++++++++++++++++++++++++
 tb/tb_hex_scroll_monitor.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scroll_monitor.sv
// rtl/hex_scroll_monitor.sv - receive-side monitor for a six-digit 7-segment scroller
//
// Purpose:
//   Registers the six active-low segment buses, decodes each glyph to a
//   digit code, filters glitches and classifies every accepted frame change
//   as a one-position rotation up, a rotation down, or an error.
//
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   RST          in   asynchronous active-high reset
//   HEX0..HEX5   in   [0:6] segment buses, segment a = bit 0, active-low
//   frame        out  last accepted frame, frame[4i+3:4i] = code of HEXi
//   frame_valid  out  high once any frame has been accepted
//   dir          out  direction of last step (1 = up, 0 = down)
//   step_pulse   out  one-cycle pulse per detected step
//   step_count   out  step counter, wraps
//   err_pulse    out  one-cycle pulse per error
//   err_count    out  error counter, saturates at 255
//   step_period  out  (HEX_MON_PERIOD_EN only) cycles between the last two steps
//
// Optional feature macro: HEX_MON_PERIOD_EN

module hex_scroll_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             CLOCK_50,
    input  logic             RST,
    input  logic [0:6]       HEX0,
    input  logic [0:6]       HEX1,
    input  logic [0:6]       HEX2,
    input  logic [0:6]       HEX3,
    input  logic [0:6]       HEX4,
    input  logic [0:6]       HEX5,
    output logic [23:0]      frame,
    output logic             frame_valid,
    output logic             dir,
    output logic             step_pulse,
    output logic [CNT_W-1:0] step_count,
    output logic             err_pulse,
`ifdef HEX_MON_PERIOD_EN
    output logic [7:0]       err_count,
    output logic [31:0]      step_period
`else
    output logic [7:0]       err_count
`endif
);

    typedef enum logic {S_EMPTY, S_LOCKED} state_t;

    localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

    function automatic logic [3:0] f_decode(input logic [0:6] s);
        case (s)
            7'b0000001: return 4'h0;
            7'b1001111: return 4'h1;
            7'b0010010: return 4'h2;
            7'b0000110: return 4'h3;
            7'b1001100: return 4'h4;
            7'b0100100: return 4'h5;
            7'b0100000: return 4'h6;
            7'b0001111: return 4'h7;
            7'b0000000: return 4'h8;
            7'b0000100: return 4'h9;
            7'b1111111: return 4'hF;
            default:    return 4'hE;
        endcase
    endfunction

    logic [0:6]       r_hex [6];
    logic             r_in_vld;
    logic [23:0]      r_cand;
    logic [7:0]       r_cnt;
    logic             r_accept;
    state_t           r_state;
    logic [23:0]      r_frame;
    logic             r_valid;
    logic             r_dir;
    logic             r_step_pulse;
    logic             r_err_pulse;
    logic [CNT_W-1:0] r_step_count;
    logic [7:0]       r_err_count;

    logic [23:0]      w_dec;
    logic             w_new_run;
    logic [7:0]       w_cnt_nxt;
    logic             w_fire;
    logic             w_has_e;
    logic             w_up;
    logic             w_dn;
    state_t           w_state_nxt;
    logic [23:0]      w_frame_nxt;
    logic             w_valid_nxt;
    logic             w_dir_nxt;
    logic             w_step;
    logic             w_err;

    always_comb begin
        w_dec = '0;
        for (int i = 0; i < 6; i++) begin
            w_dec[4*i +: 4] = f_decode(r_hex[i]);
        end
    end

    // Counter restarts at 1 on a new candidate and saturates at STABLE_CYCLES;
    // the accept fires only on the transition into saturation, so once per run.
    assign w_new_run = (w_dec != r_cand);
    assign w_cnt_nxt = w_new_run ? 8'd1 :
                       (r_cnt == LP_STABLE) ? r_cnt : r_cnt + 8'd1;
    assign w_fire    = r_in_vld && (w_cnt_nxt == LP_STABLE) &&
                       (w_new_run || (r_cnt != LP_STABLE));

    // r_in_vld keeps the filter idle until the input register holds a real
    // sample, so the reset value of r_hex can never be accepted as a frame.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 6; i++) r_hex[i] <= '0;
            r_in_vld <= 1'b0;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_accept <= 1'b0;
        end else begin
            r_hex[0] <= HEX0;
            r_hex[1] <= HEX1;
            r_hex[2] <= HEX2;
            r_hex[3] <= HEX3;
            r_hex[4] <= HEX4;
            r_hex[5] <= HEX5;
            r_in_vld <= 1'b1;
            r_accept <= w_fire;
            if (r_in_vld) begin
                r_cand <= w_dec;
                r_cnt  <= w_cnt_nxt;
            end
        end
    end

    always_comb begin
        w_has_e = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (r_cand[4*i +: 4] == 4'hE) w_has_e = 1'b1;
        end
    end

    // up: content moved toward higher HEX index; down: toward lower.
    assign w_up = (r_cand == {r_frame[19:0], r_frame[23:20]});
    assign w_dn = (r_cand == {r_frame[3:0], r_frame[23:4]});

    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_valid_nxt = r_valid;
        w_dir_nxt   = r_dir;
        w_step      = 1'b0;
        w_err       = 1'b0;
        if (r_accept) begin
            if (w_has_e) begin
                w_err = 1'b1;
            end else begin
                case (r_state)
                    S_EMPTY: begin
                        w_frame_nxt = r_cand;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_LOCKED;
                    end
                    S_LOCKED: begin
                        if (r_cand == r_frame) begin
                            w_step = 1'b0;
                        end else if (w_up || w_dn) begin
                            // Period-2 content matches both ways: direction is ambiguous, keep it.
                            w_step      = 1'b1;
                            w_frame_nxt = r_cand;
                            if (w_up && !w_dn) w_dir_nxt = 1'b1;
                            if (w_dn && !w_up) w_dir_nxt = 1'b0;
                        end else begin
                            w_err       = 1'b1;
                            w_frame_nxt = r_cand;
                        end
                    end
                    default: w_state_nxt = S_EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            r_state      <= S_EMPTY;
            r_frame      <= '0;
            r_valid      <= 1'b0;
            r_dir        <= 1'b0;
            r_step_pulse <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_step_count <= '0;
            r_err_count  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame      <= w_frame_nxt;
            r_valid      <= w_valid_nxt;
            r_dir        <= w_dir_nxt;
            r_step_pulse <= w_step;
            r_err_pulse  <= w_err;
            if (w_step) r_step_count <= r_step_count + CNT_W'(1);
            if (w_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
        end
    end

    assign frame       = r_frame;
    assign frame_valid = r_valid;
    assign dir         = r_dir;
    assign step_pulse  = r_step_pulse;
    assign step_count  = r_step_count;
    assign err_pulse   = r_err_pulse;
    assign err_count   = r_err_count;

`ifdef HEX_MON_PERIOD_EN
    logic [31:0] r_per_cnt;
    logic [31:0] r_period;
    logic        r_seen_step;

    // The counter restarts at 1 in the cycle after a pulse, so the value
    // captured at the next pulse equals the pulse-to-pulse spacing.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            r_per_cnt   <= '0;
            r_period    <= '0;
            r_seen_step <= 1'b0;
        end else if (r_step_pulse) begin
            r_per_cnt   <= 32'd1;
            r_seen_step <= 1'b1;
            if (r_seen_step) r_period <= r_per_cnt;
        end else if (r_per_cnt != 32'hFFFF_FFFF) begin
            r_per_cnt <= r_per_cnt + 32'd1;
        end
    end

    assign step_period = r_period;
`endif

endmodule

// File: tb/tb_hex_scroll_monitor.sv
// tb/tb_hex_scroll_monitor.sv - self-checking bench for hex_scroll_monitor

module tb_hex_scroll_monitor;

    localparam int SC = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [0:6]    hex [6];
    logic [23:0]   frame;
    logic          frame_valid;
    logic          dir;
    logic          step_pulse;
    logic [CW-1:0] step_count;
    logic          err_pulse;
    logic [7:0]    err_count;
`ifdef HEX_MON_PERIOD_EN
    logic [31:0]   step_period;
`endif

    hex_scroll_monitor #(.STABLE_CYCLES(SC), .CNT_W(CW)) dut (
        .CLOCK_50   (clk),
        .RST        (rst),
        .HEX0       (hex[0]),
        .HEX1       (hex[1]),
        .HEX2       (hex[2]),
        .HEX3       (hex[3]),
        .HEX4       (hex[4]),
        .HEX5       (hex[5]),
        .frame      (frame),
        .frame_valid(frame_valid),
        .dir        (dir),
        .step_pulse (step_pulse),
        .step_count (step_count),
        .err_pulse  (err_pulse),
`ifdef HEX_MON_PERIOD_EN
        .err_count  (err_count),
        .step_period(step_period)
`else
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        bit            is_err;
        logic          dir;
        logic [CW-1:0] sc;
        logic [7:0]    ec;
        logic [23:0]   frame;
        int            cyc;
    } exp_t;

    exp_t q[$];

    // frame-level reference model
    bit            m_locked;
    logic [23:0]   m_frame;
    logic          m_dir;
    logic [CW-1:0] m_sc;
    logic [7:0]    m_ec;
    logic [23:0]   prev_in;
    bit            fresh;

    function automatic logic [0:6] seg(input logic [3:0] c);
        case (c)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hF: return 7'b1111111;
            default: return 7'b1010101;
        endcase
    endfunction

    function automatic logic [3:0] dig(input logic [23:0] f, input int i);
        return f[4*i +: 4];
    endfunction

    task automatic push_evt(input bit is_err, input int c);
        exp_t e;
        e.is_err = is_err;
        e.dir    = m_dir;
        e.sc     = m_sc;
        e.ec     = m_ec;
        e.frame  = m_frame;
        e.cyc    = c;
        q.push_back(e);
    endtask

    task automatic model_eval(input logic [23:0] f, input int c);
        bit has_e, up, dn;
        has_e = 0;
        for (int i = 0; i < 6; i++) if (dig(f, i) == 4'hE) has_e = 1;
        if (has_e) begin
            if (m_ec != 8'd255) m_ec++;
            push_evt(1, c);
        end else if (!m_locked) begin
            m_locked = 1;
            m_frame  = f;
        end else if (f != m_frame) begin
            up = 1;
            dn = 1;
            for (int i = 0; i < 6; i++) begin
                if (dig(f, i) != dig(m_frame, (i + 5) % 6)) up = 0;
                if (dig(f, i) != dig(m_frame, (i + 1) % 6)) dn = 0;
            end
            m_frame = f;
            if (up || dn) begin
                if (up && !dn) m_dir = 1;
                if (dn && !up) m_dir = 0;
                m_sc++;
                push_evt(0, c);
            end else begin
                if (m_ec != 8'd255) m_ec++;
                push_evt(1, c);
            end
        end
    endtask

    // Caller is at a negedge; drives the frame and holds it for n clock edges.
    task automatic apply(input logic [23:0] f, input int n);
        bit newrun;
        for (int i = 0; i < 6; i++) hex[i] = seg(f[4*i +: 4]);
        newrun  = fresh || (f != prev_in);
        prev_in = f;
        fresh   = 0;
        if (newrun && n >= SC) model_eval(f, cyc + 2 + SC);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_frame  = '0;
        m_dir    = 0;
        m_sc     = '0;
        m_ec     = '0;
        fresh    = 1;
    endtask

    always @(negedge clk) begin
        if (!rst && (step_pulse || err_pulse)) begin
            nvec++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_pulse cyc=%0d step=%b err=%b frame=%h required no pulse",
                         cyc, step_pulse, err_pulse, frame);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (err_pulse !== e.is_err || step_pulse !== !e.is_err || cyc !== e.cyc ||
                    dir !== e.dir || step_count !== e.sc || err_count !== e.ec || frame !== e.frame) begin
                    nerr++;
                    $display("FAIL pulse_event got err=%b step=%b cyc=%0d dir=%b sc=%0d ec=%0d frame=%h required err=%b step=%b cyc=%0d dir=%b sc=%0d ec=%0d frame=%h",
                             err_pulse, step_pulse, cyc, dir, step_count, err_count, frame,
                             e.is_err, !e.is_err, e.cyc, e.dir, e.sc, e.ec, e.frame);
                end
            end
        end
    end

    task automatic test_reset();
        int c;
        rst = 1;
        for (int i = 0; i < 6; i++) hex[i] = seg(dig(24'hFF9500, i));
        repeat (3) @(negedge clk);
        nvec++;
        if ({frame, frame_valid, dir, step_pulse, step_count, err_pulse, err_count} !== '0) begin
            nerr++;
            $display("FAIL reset_state frame=%h valid=%b dir=%b sc=%0d ec=%0d required all zero",
                     frame, frame_valid, dir, step_count, err_count);
        end
        model_reset();
        rst = 0;
        c = cyc;
        repeat (5) @(negedge clk);
        nvec++;
        if (frame_valid !== 1'b0) begin
            nerr++;
            $display("FAIL valid_early cyc=%0d got %b required 0", cyc - c, frame_valid);
        end
        @(negedge clk);
        nvec++;
        if (frame_valid !== 1'b1 || frame !== 24'hFF9500 || step_count !== '0 || err_count !== 8'd0) begin
            nerr++;
            $display("FAIL first_lock valid=%b frame=%h sc=%0d ec=%0d required 1 ff9500 0 0",
                     frame_valid, frame, step_count, err_count);
        end
        m_locked = 1;
        m_frame  = 24'hFF9500;
        prev_in  = 24'hFF9500;
        fresh    = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rotate();
        apply(24'h9500FF, 8);
        apply(24'h500FF9, 8);
        nvec++;
        if (dir !== 1'b1 || frame !== 24'h500FF9) begin
            nerr++;
            $display("FAIL rotate_up dir=%b frame=%h required 1 500ff9", dir, frame);
        end
        apply(24'h9500FF, 8);
        nvec++;
        if (dir !== 1'b0 || step_count !== CW'(2)) begin
            nerr++;
            $display("FAIL rotate_down dir=%b sc=%0d required 0 2", dir, step_count);
        end
    endtask

    task automatic test_glitch();
        apply(24'h9502FF, SC - 1);
        apply(24'h9500FF, 8);
        nvec++;
        if (frame !== 24'h9500FF || err_count !== m_ec || step_count !== m_sc) begin
            nerr++;
            $display("FAIL short_glitch frame=%h ec=%0d sc=%0d required 9500ff %0d %0d",
                     frame, err_count, step_count, m_ec, m_sc);
        end
        apply(24'h9502FF, 8);
        nvec++;
        if (frame !== 24'h9502FF) begin
            nerr++;
            $display("FAIL long_glitch frame=%h required 9502ff", frame);
        end
    endtask

    task automatic test_invalid();
        logic [7:0] ec0;
        ec0 = m_ec;
        apply(24'h9502EF, 8);
        nvec++;
        if (err_count !== ec0 + 8'd1 || frame !== 24'h9502FF) begin
            nerr++;
            $display("FAIL invalid_glyph ec=%0d frame=%h required %0d 9502ff", err_count, frame, ec0 + 8'd1);
        end
        for (int k = 0; k < 300; k++) begin
            apply(24'h9502FF, 5);
            apply(24'h9502EF, 5);
        end
        repeat (4) @(negedge clk);
        nvec++;
        if (err_count !== 8'd255) begin
            nerr++;
            $display("FAIL err_saturate got %0d required 255", err_count);
        end
    endtask

    task automatic test_period2();
        logic d0;
        apply(24'h9F9F9F, 8);
        d0 = dir;
        apply(24'hF9F9F9, 8);
        nvec++;
        if (dir !== d0 || frame !== 24'hF9F9F9) begin
            nerr++;
            $display("FAIL period2 dir=%b frame=%h required %b f9f9f9", dir, frame, d0);
        end
        apply(24'h123456, 8);
        nvec++;
        if (frame !== 24'h123456) begin
            nerr++;
            $display("FAIL resync frame=%h required 123456", frame);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] f;
        f = 24'h123456;
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 1) == 1) f = {f[19:0], f[23:20]};
            else                           f = {f[3:0], f[23:4]};
            apply(f, SC);
        end
        repeat (8) @(negedge clk);
        nvec++;
        if (step_count !== m_sc || frame !== f) begin
            nerr++;
            $display("FAIL back_to_back sc=%0d frame=%h required %0d %h", step_count, frame, m_sc, f);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] f;
        f = {m_frame[19:0], m_frame[23:20]};
        for (int i = 0; i < 6; i++) hex[i] = seg(dig(f, i));
        prev_in = f;
        model_eval(f, cyc + 2 + SC);
        repeat (2 + SC) @(negedge clk);
        #1 rst = 1;
        #1;
        nvec++;
        if ({frame, frame_valid, dir, step_pulse, step_count, err_pulse, err_count} !== '0) begin
            nerr++;
            $display("FAIL mid_reset frame=%h valid=%b dir=%b step=%b sc=%0d err=%b ec=%0d required all zero",
                     frame, frame_valid, dir, step_pulse, step_count, err_pulse, err_count);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
        apply(f, 8);
        nvec++;
        if (frame_valid !== 1'b1 || frame !== f || step_count !== '0 || err_count !== 8'd0) begin
            nerr++;
            $display("FAIL relock valid=%b frame=%h sc=%0d ec=%0d required 1 %h 0 0",
                     frame_valid, frame, step_count, err_count, f);
        end
`ifdef HEX_MON_PERIOD_EN
        f = {f[19:0], f[23:20]};
        apply(f, 1000);
        nvec++;
        if (step_period !== 32'd0) begin
            nerr++;
            $display("FAIL period_first got %0d required 0", step_period);
        end
        f = {f[19:0], f[23:20]};
        apply(f, 10);
        nvec++;
        if (step_period !== 32'd1000) begin
            nerr++;
            $display("FAIL period_1000 got %0d required 1000", step_period);
        end
`else
        f = {f[3:0], f[23:4]};
        apply(f, 8);
        nvec++;
        if (step_count !== CW'(1) || dir !== 1'b0) begin
            nerr++;
            $display("FAIL post_reset_step sc=%0d dir=%b required 1 0", step_count, dir);
        end
`endif
    endtask

    initial begin
        rst = 1;
        for (int i = 0; i < 6; i++) hex[i] = 7'b1111111;
        model_reset();
        prev_in = '0;
        @(negedge clk);
        test_reset();
        test_rotate();
        test_glitch();
        test_invalid();
        test_period2();
        test_back_to_back();
        test_reset_mid();
        repeat (10) @(negedge clk);
        nvec++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL missing_pulses %0d expected events never seen, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
